// File: rtl/sysid_checker_pkg.sv
// Shared types and default constants for the sysid_checker block.
package sysid_checker_pkg;

  // Sequencer states: idle, read ID word, read timestamp word, finished.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1671500684;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 255;

endpackage : sysid_checker_pkg

// File: rtl/sysid_checker.sv
// sysid_checker: reads the two words of an Avalon-MM sysid slave (ID, then
// build timestamp), captures them and compares them against the expected
// values. Optional feature macro SYSID_CHECKER_TIMEOUT_EN adds a per-read
// wait-request limit that aborts a stuck read and raises timeout.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout
);

  // The wait counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sysid_checker: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      r_state;
  logic        r_avm_address;
  logic        r_avm_read;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  // The counter value at which one more stalled cycle hits the limit.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wait_cnt;
  logic        r_timeout;
`endif

  // Sequencer: single registered FSM driving the bus strobes and result flags.
  always_ff @(posedge clock) begin
    // NOTE: all state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      r_state       <= IDLE;
      r_avm_address <= 1'b0;
      r_avm_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_id_value    <= '0;
      r_ts_value    <= '0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (start) begin
            r_state       <= RD_ID;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout     <= 1'b0;
`endif
          end
        end

        RD_ID: begin
          if (!avm_waitrequest) begin
            r_id_value    <= avm_readdata;
            r_state       <= RD_TS;
            r_avm_address <= 1'b1;
`ifdef SYSID_CHECKER_TIMEOUT_EN
            r_wait_cnt    <= '0;
          end else if (r_wait_cnt == TIMEOUT_LAST) begin
            r_state       <= FIN;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_timeout     <= 1'b1;
          end else begin
            r_wait_cnt    <= r_wait_cnt + 16'd1;
`endif
          end
        end

        RD_TS: begin
          if (!avm_waitrequest) begin
            r_ts_value    <= avm_readdata;
            r_state       <= FIN;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_id_ok       <= (r_id_value == EXPECTED_ID);
            r_ts_ok       <= (avm_readdata == EXPECTED_TS);
`ifdef SYSID_CHECKER_TIMEOUT_EN
          end else if (r_wait_cnt == TIMEOUT_LAST) begin
            r_state       <= FIN;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_timeout     <= 1'b1;
          end else begin
            r_wait_cnt    <= r_wait_cnt + 16'd1;
`endif
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
`ifdef SYSID_CHECKER_TIMEOUT_EN
  assign timeout     = r_timeout;
`else
  assign timeout     = 1'b0;
`endif

endmodule : sysid_checker

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 32'h0000_0000, the system ID value expected at slave word 0.
REQ-002 The block SHALL have parameter EXPECTED_TS, default 32'd1671500684, the build timestamp expected at slave word 1.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, the maximum wait-request cycles per read.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to run a check sequence.
REQ-007 The block SHALL have port avm_address, output, 1 bit: the sysid slave word select (0 = ID, 1 = timestamp).
REQ-008 The block SHALL have port avm_read, output, 1 bit: the Avalon-MM read strobe.
REQ-009 The block SHALL have port avm_waitrequest, input, 1 bit: the slave stall; a read completes in the first cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 The block SHALL have port avm_readdata, input, 32 bits: the slave read data, valid in the completing cycle.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a sticky completion flag, cleared by start or reset.
REQ-013 The block SHALL have ports id_ok and ts_ok, output, 1 bit each: the comparison results, valid while done=1.
REQ-014 The block SHALL have ports id_value and ts_value, output, 32 bits each: the captured read data.
REQ-015 The block SHALL have port timeout, output, 1 bit: a sticky abort flag, valid while done=1.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RD_ID, RD_TS, and FIN.
REQ-017 In IDLE or FIN, start=1 SHALL clear done, id_ok, ts_ok, and timeout, and enter RD_ID on the next cycle.
REQ-018 In RD_ID, the block SHALL drive avm_read=1 and avm_address=0.
REQ-019 On the completing RD_ID cycle, the block SHALL capture avm_readdata into id_value and enter RD_TS.
REQ-020 In RD_TS, the block SHALL drive avm_read=1 and avm_address=1.
REQ-021 On the completing RD_TS cycle, the block SHALL capture avm_readdata into ts_value and enter FIN.
REQ-022 On entry to FIN, done SHALL be 1; id_ok SHALL be (id_value==EXPECTED_ID) and ts_ok SHALL be (ts_value==EXPECTED_TS), compared over the full 32 bits.
REQ-023 With a zero-wait slave, the minimum latency SHALL be start to done = 3 cycles (RD_ID 1 cycle, RD_TS 1 cycle, then FIN).
REQ-024 Outside RD_ID and RD_TS, avm_read SHALL be 0 and avm_address SHALL be 0.
REQ-025 busy SHALL be 1 exactly in states RD_ID and RD_TS.
REQ-026 start SHALL be ignored while busy=1; no restart and no flag change SHALL occur.
REQ-027 avm_address SHALL hold stable throughout a stalled read.

Reset
REQ-028 While reset=1, the FSM SHALL go to IDLE and every output SHALL be 0 (avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value).
REQ-029 A reset asserted mid-read SHALL drop avm_read on the cycle after the reset edge; no capture SHALL occur.
REQ-030 When reset and start are both asserted in the same cycle, reset SHALL take precedence.

Configuration
REQ-031 With macro SYSID_CHECKER_TIMEOUT_EN defined, a 16-bit wait counter SHALL clear on each entry to RD_ID or RD_TS and increment on each cycle with avm_waitrequest=1.
REQ-032 With SYSID_CHECKER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES while still stalled, the FSM SHALL go to FIN with avm_read=0 next cycle, timeout=1, id_ok=0, and ts_ok=0.
REQ-033 Without SYSID_CHECKER_TIMEOUT_EN, there SHALL be no counter, reads SHALL wait indefinitely, and timeout SHALL be tied to 0.

Structure
REQ-034 The package sysid_checker_pkg SHALL hold the state enum type and the default EXPECTED_ID, EXPECTED_TS, and TIMEOUT_CYCLES constants.
REQ-035 The block SHALL be a single module with no sub-module; the timeout counter is inline logic.

Verification
REQ-036 The bench SHALL cover: zero-wait slave returning 0 then 1671500684, one start pulse -> done=1 after 3 cycles, id_ok=1, ts_ok=1, timeout=0.
REQ-037 The bench SHALL cover: timestamp word returning 32'h12345678 -> ts_ok=0, id_ok=1, ts_value=32'h12345678.
REQ-038 The bench SHALL cover: waitrequest high for 5 cycles on each read -> done after 13 cycles, with avm_address stable during each stall.
REQ-039 The bench SHALL cover, with SYSID_CHECKER_TIMEOUT_EN defined and TIMEOUT_CYCLES=4: waitrequest stuck high -> timeout=1, done=1, and avm_read low within 6 cycles of start.
REQ-040 The bench SHALL cover: reset asserted during a stalled RD_TS -> all outputs 0 next cycle; a subsequent start completes normally.
REQ-041 The bench SHALL cover: start re-pulsed while busy -> ignored; start pulsed in FIN -> flags cleared and the sequence rerun.
